// File: rtl/action_encoder.sv
// Button front end for the fighting game core: synchronises and debounces raw buttons,
// latches presses until the next game tick and issues one action code per player per tick.
module action_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] btn1,
  input  logic [5:0] btn2,
  input  logic       btn_pause,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       control,
  output logic       tick
);

  localparam int NB     = 13;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TCNT_W = $clog2(TICK_DIV);
  localparam logic [2:0]        NOP        = 3'b110;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TICK_DIV - 1);

  // Lowest set bit wins, so kick beats everything and right loses to everything.
  function automatic logic [2:0] first_set(input logic [5:0] p);
    logic [2:0] idx;
    idx = NOP;
    for (int i = 5; i >= 0; i--) begin
      if (p[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [NB-1:0]     raw;
  logic [NB-1:0]     sync_p0;
  logic [NB-1:0]     sync_p1;
  logic [NB-1:0]     stable_p2;
  logic [NB-1:0]     flip;
  logic [NB-1:0]     rise;
  logic [CNT_W-1:0]  db_cnt [NB];
  logic [TCNT_W-1:0] tick_cnt;
  logic              tick_edge;
  logic [5:0]        pend1;
  logic [5:0]        pend2;

  assign raw = {btn_pause, btn2, btn1};

  // A bit flips on the edge its counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    flip = '0;
    for (int b = 0; b < NB; b++) begin
      flip[b] = (sync_p1[b] != stable_p2[b]) && (db_cnt[b] == CNT_LAST);
    end
  end

  assign rise      = flip & sync_p1;
  assign tick_edge = (tick_cnt == TCNT_LAST);

  // Stage p0/p1: two-flop synchroniser; stage p2: debounced stable level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable_p2 <= '0;
      for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
    end else begin
      sync_p0   <= raw;
      sync_p1   <= sync_p0;
      stable_p2 <= stable_p2 ^ flip;
      for (int b = 0; b < NB; b++) begin
        if ((sync_p1[b] == stable_p2[b]) || flip[b]) db_cnt[b] <= '0;
        else                                         db_cnt[b] <= db_cnt[b] + CNT_W'(1);
      end
    end
  end

  // Tick stage: pending presses arbitrated into registered action codes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      pend1    <= '0;
      pend2    <= '0;
      action1  <= NOP;
      action2  <= NOP;
      control  <= 1'b1;
      tick     <= 1'b0;
    end else begin
      tick_cnt <= tick_edge ? '0 : tick_cnt + TCNT_W'(1);
      tick     <= tick_edge;
      // A press landing on the tick edge survives as the only pending bit.
      pend1    <= control ? ((tick_edge ? 6'd0 : pend1) | rise[5:0])  : 6'd0;
      pend2    <= control ? ((tick_edge ? 6'd0 : pend2) | rise[11:6]) : 6'd0;
      if (tick_edge) begin
        action1 <= control ? first_set(pend1) : NOP;
        action2 <= control ? first_set(pend2) : NOP;
      end
      control  <= control ^ rise[12];
    end
  end

endmodule

// File: tb/tb_action_encoder.sv
// Directed bench for action_encoder with a window-based behavioural model checked every cycle.
module tb_action_encoder;

  localparam int DB = 4;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] btn1 = '0;
  logic [5:0] btn2 = '0;
  logic       btn_pause = 1'b0;
  logic [2:0] action1;
  logic [2:0] action2;
  logic       control;
  logic       tick;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  action_encoder #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .btn_pause(btn_pause),
    .action1(action1), .action2(action2), .control(control), .tick(tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] prio(input logic [5:0] p);
    logic [2:0] r;
    r = 3'd6;
    for (int i = 5; i >= 0; i--) if (p[i]) r = 3'(i);
    return r;
  endfunction

  // Model: a bit's stable level flips once the last DB synchronised samples
  // (raw samples two edges old) all disagree with it.
  logic [12:0] hist [0:DB+1];
  logic [12:0] m_stable;
  logic [5:0]  m_pend1, m_pend2;
  logic [2:0]  m_act1, m_act2;
  logic        m_ctl, m_tick;
  int          m_n;

  task automatic model_reset();
    for (int k = 0; k <= DB + 1; k++) hist[k] = '0;
    m_stable = '0; m_pend1 = '0; m_pend2 = '0;
    m_act1 = 3'd6; m_act2 = 3'd6; m_ctl = 1'b1; m_tick = 1'b0; m_n = 0;
  endtask

  task automatic model_step();
    logic [12:0] rise;
    logic        all_diff, old_ctl, tick_edge;
    m_n++;
    tick_edge = (m_n % TD) == 0;
    for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {btn_pause, btn2, btn1};
    rise = '0;
    for (int b = 0; b < 13; b++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= DB + 1; k++) if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) begin
        if (!m_stable[b]) rise[b] = 1'b1;
        m_stable[b] = ~m_stable[b];
      end
    end
    old_ctl = m_ctl;
    if (tick_edge) begin
      m_act1  = old_ctl ? prio(m_pend1) : 3'd6;
      m_act2  = old_ctl ? prio(m_pend2) : 3'd6;
      m_pend1 = old_ctl ? rise[5:0]  : 6'd0;
      m_pend2 = old_ctl ? rise[11:6] : 6'd0;
    end else begin
      m_pend1 = old_ctl ? (m_pend1 | rise[5:0])  : 6'd0;
      m_pend2 = old_ctl ? (m_pend2 | rise[11:6]) : 6'd0;
    end
    m_tick = tick_edge;
    if (rise[12]) m_ctl = ~m_ctl;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("cmp_rst_action1", action1, 3'd6);
        check("cmp_rst_action2", action2, 3'd6);
        check("cmp_rst_control", control, 1'b1);
        check("cmp_rst_tick", tick, 1'b0);
      end else begin
        check("cmp_action1", action1, m_act1);
        check("cmp_action2", action2, m_act2);
        check("cmp_control", control, m_ctl);
        check("cmp_tick", tick, m_tick);
      end
    end
  end

  task automatic wait_tick(input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin found = 1; break; end
    end
    if (!found) check("tick_timeout", 0, 1);
  endtask

  task automatic wait_issue(input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick === 1'b1 && (action1 !== 3'd6 || action2 !== 3'd6)) begin found = 1; break; end
    end
    if (!found) check("issue_timeout", 0, 1);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check("rst_action1", action1, 3'd6);
    check("rst_control", control, 1'b1);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("tick_before_first", tick, 1'b0);
    end
    @(negedge clk);
    check("tick_first", tick, 1'b1);

    // single press of punch
    btn1[1] = 1'b1;
    fork begin repeat (10) @(negedge clk); btn1[1] = 1'b0; end join_none
    wait_issue(40);
    check("single_action1", action1, 3'd1);
    check("single_action2", action2, 3'd6);
    repeat (3) begin
      @(negedge clk);
      check("single_hold", action1, 3'd1);
    end
    @(negedge clk);
    check("single_next_nop", action1, 3'd6);

    // 3-cycle glitch on player 2 kick
    repeat (12) @(negedge clk);
    btn2[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn2[0] = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (action2 !== 3'd6) bad++;
    end
    check("glitch_action2", bad, 0);

    // jump and right together: jump wins, right is dropped
    btn1[5] = 1'b1; btn1[3] = 1'b1;
    fork begin repeat (10) @(negedge clk); btn1[5] = 1'b0; btn1[3] = 1'b0; end join_none
    wait_issue(40);
    check("prio_action1", action1, 3'd3);
    repeat (4) @(negedge clk);
    check("prio_next_tick", tick, 1'b1);
    check("prio_no_carry", action1, 3'd6);

    // both players on the same tick
    repeat (12) @(negedge clk);
    btn1[2] = 1'b1; btn2[1] = 1'b1;
    fork begin repeat (10) @(negedge clk); btn1[2] = 1'b0; btn2[1] = 1'b0; end join_none
    wait_issue(40);
    check("both_action1", action1, 3'd2);
    check("both_action2", action2, 3'd1);

    // stable rise of left exactly on a tick edge
    repeat (16) @(negedge clk);
    wait_tick(10);
    repeat (2) @(negedge clk);
    btn1[4] = 1'b1;
    wait_tick(10);
    check("edge_period0", action1, 3'd6);
    wait_tick(10);
    check("edge_period1", action1, 3'd6);
    wait_tick(10);
    check("edge_period2", action1, 3'd4);
    btn1[4] = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_rst_action1", action1, 3'd6);
    check("async_rst_tick", tick, 1'b0);
    check("async_rst_control", control, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // pause, presses ignored, resume
    repeat (8) @(negedge clk);
    btn_pause = 1'b1;
    repeat (10) @(negedge clk);
    btn_pause = 1'b0;
    repeat (4) @(negedge clk);
    check("pause_control", control, 1'b0);
    btn1[0] = 1'b1; btn2[2] = 1'b1;
    repeat (10) @(negedge clk);
    btn1[0] = 1'b0; btn2[2] = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (action1 !== 3'd6 || action2 !== 3'd6) bad++;
    end
    check("pause_nop", bad, 0);
    btn_pause = 1'b1;
    repeat (10) @(negedge clk);
    btn_pause = 1'b0;
    check("resume_control", control, 1'b1);
    repeat (10) @(negedge clk);
    btn2[2] = 1'b1;
    fork begin repeat (10) @(negedge clk); btn2[2] = 1'b0; end join_none
    wait_issue(40);
    check("resume_action2", action2, 3'd2);
    check("resume_action1", action1, 3'd6);

    // reset drops a pending press
    repeat (16) @(negedge clk);
    wait_tick(10);
    btn1[1] = 1'b1;
    repeat (6) @(negedge clk);
    btn1[1] = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_action1", action1, 3'd6);
    check("midrst_control", control, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_tick(10);
    check("midrst_drop0", action1, 3'd6);
    wait_tick(10);
    check("midrst_drop1", action1, 3'd6);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", n_vec, n_miss);
    $fatal(1);
  end

endmodule
